// File: rtl/cmd_dispatch.sv
// UART command frame parser that dispatches bus transactions
// and returns a framed status/readback response.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rx_data/valid/ready   inbound byte stream (ready driven here)
//   tx_data/valid/ready   outbound response stream
//   bus_start/ch/dir/addr/len/wdata   transaction request
//   bus_rdata/done/err    transaction completion
//   err_count       saturating count of dropped frames
module cmd_dispatch #(
  parameter int NCH     = 4,
  parameter int MAX_LEN = 4,
  parameter int RX_TMO  = 100000,
  parameter int BUS_TMO = 10000,
  localparam int CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic                   rx_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   bus_start,
  output logic [CHW-1:0]         bus_ch,
  output logic                   bus_dir,
  output logic [7:0]             bus_addr,
  output logic [4:0]             bus_len,
  output logic [8*MAX_LEN-1:0]   bus_wdata,
  input  logic [8*MAX_LEN-1:0]   bus_rdata,
  input  logic                   bus_done,
  input  logic                   bus_err,
  output logic [7:0]             err_count
);

  localparam int RTW = $clog2(RX_TMO + 1);
  localparam int BTW = $clog2(BUS_TMO + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_OP, S_CH, S_ADDR, S_LEN, S_DATA,
    S_CSUM, S_CR, S_LF, S_EXEC, S_WAIT, S_RESP
  } state_t;

  state_t               r_state;
  state_t               r_state_n;
  logic [7:0]           r_op;
  logic [CHW-1:0]       r_ch;
  logic [7:0]           r_addr;
  logic [4:0]           r_len;
  logic [4:0]           r_idx;
  logic [8*MAX_LEN-1:0] r_wdata;
  logic [8*MAX_LEN-1:0] r_rdata;
  logic [7:0]           r_csum;
  logic [7:0]           r_rxcsum;
  logic [7:0]           r_status;
  logic [7:0]           r_rcsum;
  logic [4:0]           r_nb;
  logic [5:0]           r_txi;
  logic [RTW-1:0]       r_rtmr;
  logic [BTW-1:0]       r_btmr;
  logic [7:0]           r_err_count;

  logic                 w_rx_acc;
  logic                 w_tx_acc;
  logic                 w_in_frame;
  logic                 w_rtmo;
  logic                 w_btmo;
  logic                 w_csum_ok;
  logic                 w_tx_last;
  logic                 w_err;
  logic [7:0]           w_rxor;
  logic [5:0]           w_ri;
  logic [5:0]           w_j;

  assign w_rx_acc   = rx_valid & rx_ready;
  assign w_tx_acc   = tx_valid & tx_ready;
  assign w_in_frame = (r_state >= S_OP) && (r_state <= S_LF);
  assign w_rtmo     = w_in_frame && !w_rx_acc &&
                      (r_rtmr == RTW'(RX_TMO - 1));
  assign w_btmo     = (r_btmr == BTW'(BUS_TMO - 1));
  assign w_csum_ok  = (r_csum == r_rxcsum);
  assign w_tx_last  = (r_txi == (6'(r_nb) + 6'd5));

  // XOR of the first r_len read bytes for the response checksum
  always_comb begin
    w_rxor = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (5'(i) < r_len) w_rxor = w_rxor ^ bus_rdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= r_state_n;
  end

  always_comb begin
    r_state_n = r_state;
    w_err     = 1'b0;
    unique case (r_state)
      S_IDLE: if (w_rx_acc && rx_data == 8'h55) r_state_n = S_HDR1;
      S_HDR1: if (w_rx_acc) begin
        if (rx_data == 8'h5D)      r_state_n = S_OP;
        else if (rx_data != 8'h55) r_state_n = S_IDLE;
      end
      S_OP: if (w_rx_acc) begin
        if (rx_data == 8'h01 || rx_data == 8'h02) r_state_n = S_CH;
        else begin r_state_n = S_IDLE; w_err = 1'b1; end
      end
      S_CH: if (w_rx_acc) begin
        if (rx_data < 8'(NCH)) r_state_n = S_ADDR;
        else begin r_state_n = S_IDLE; w_err = 1'b1; end
      end
      S_ADDR: if (w_rx_acc) r_state_n = S_LEN;
      S_LEN: if (w_rx_acc) begin
        if (rx_data == 8'h00 || rx_data > 8'(MAX_LEN)) begin
          r_state_n = S_IDLE;
          w_err     = 1'b1;
        end else if (r_op == 8'h01) r_state_n = S_DATA;
        else                        r_state_n = S_CSUM;
      end
      S_DATA: if (w_rx_acc && r_idx == r_len - 5'd1) r_state_n = S_CSUM;
      S_CSUM: if (w_rx_acc) r_state_n = S_CR;
      S_CR: if (w_rx_acc) begin
        if (rx_data == 8'h0D) r_state_n = S_LF;
        else begin r_state_n = S_IDLE; w_err = 1'b1; end
      end
      S_LF: if (w_rx_acc) begin
        if (rx_data != 8'h0A) begin r_state_n = S_IDLE; w_err = 1'b1; end
        else if (w_csum_ok)   r_state_n = S_EXEC;
        else                  r_state_n = S_RESP;
      end
      S_EXEC: r_state_n = S_WAIT;
      S_WAIT: if (bus_done || w_btmo) r_state_n = S_RESP;
      S_RESP: if (w_tx_acc && w_tx_last) r_state_n = S_IDLE;
      default: r_state_n = S_IDLE;
    endcase
    if (w_rtmo) begin
      r_state_n = S_IDLE;
      w_err     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= '0;
      r_ch        <= '0;
      r_addr      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_csum      <= '0;
      r_rxcsum    <= '0;
      r_status    <= '0;
      r_rcsum     <= '0;
      r_nb        <= '0;
      r_txi       <= '0;
      r_rtmr      <= '0;
      r_btmr      <= '0;
      r_err_count <= '0;
    end else begin
      if (!w_in_frame || w_rx_acc) r_rtmr <= '0;
      else                         r_rtmr <= r_rtmr + 1'b1;
      if (w_err && r_err_count != 8'hFF)
        r_err_count <= r_err_count + 8'd1;
      unique case (r_state)
        S_HDR1: if (w_rx_acc && rx_data == 8'h5D) begin
          r_wdata <= '0;
          r_idx   <= '0;
        end
        S_OP: if (w_rx_acc) begin
          r_op   <= rx_data;
          r_csum <= rx_data;
        end
        S_CH: if (w_rx_acc) begin
          r_csum <= r_csum ^ rx_data;
          if (rx_data < 8'(NCH)) r_ch <= rx_data[CHW-1:0];
        end
        S_ADDR: if (w_rx_acc) begin
          r_addr <= rx_data;
          r_csum <= r_csum ^ rx_data;
        end
        S_LEN: if (w_rx_acc) begin
          r_csum <= r_csum ^ rx_data;
          if (rx_data != 8'h00 && rx_data <= 8'(MAX_LEN))
            r_len <= rx_data[4:0];
        end
        S_DATA: if (w_rx_acc) begin
          r_wdata[8*r_idx +: 8] <= rx_data;
          r_idx  <= r_idx + 5'd1;
          r_csum <= r_csum ^ rx_data;
        end
        S_CSUM: if (w_rx_acc) r_rxcsum <= rx_data;
        S_LF: if (w_rx_acc && rx_data == 8'h0A && !w_csum_ok) begin
          r_status <= 8'hE1;
          r_rcsum  <= 8'hE1;
          r_nb     <= '0;
          r_txi    <= '0;
        end
        S_EXEC: r_btmr <= '0;
        S_WAIT: begin
          r_btmr <= r_btmr + 1'b1;
          r_txi  <= '0;
          if (bus_done) begin
            r_rdata <= bus_rdata;
            if (bus_err) begin
              r_status <= 8'hE3;
              r_rcsum  <= 8'hE3;
              r_nb     <= '0;
            end else begin
              r_status <= 8'h00;
              r_rcsum  <= (r_op == 8'h02) ? w_rxor : 8'h00;
              r_nb     <= (r_op == 8'h02) ? r_len : 5'd0;
            end
          end else if (w_btmo) begin
            r_status <= 8'hE2;
            r_rcsum  <= 8'hE2;
            r_nb     <= '0;
          end
        end
        S_RESP: if (w_tx_acc) r_txi <= r_txi + 6'd1;
        default: ;
      endcase
    end
  end

  // Response byte index: header(2), status, readback(r_nb), rcsum, CR, LF
  always_comb begin
    w_ri    = r_txi - 6'd3;
    w_j     = w_ri - 6'(r_nb);
    tx_data = 8'h00;
    if (r_state == S_RESP && !rst) begin
      if (r_txi == 6'd0)           tx_data = 8'h55;
      else if (r_txi == 6'd1)      tx_data = 8'h5D;
      else if (r_txi == 6'd2)      tx_data = r_status;
      else if (w_ri < 6'(r_nb))    tx_data = r_rdata[8*w_ri +: 8];
      else if (w_j == 6'd0)        tx_data = r_rcsum;
      else if (w_j == 6'd1)        tx_data = 8'h0D;
      else                         tx_data = 8'h0A;
    end
  end

  assign tx_valid  = (r_state == S_RESP) && !rst;
  assign bus_start = (r_state == S_EXEC) && !rst;
  assign rx_ready  = !rst && (r_state != S_EXEC) &&
                     (r_state != S_WAIT) && (r_state != S_RESP);
  assign bus_ch    = r_ch;
  assign bus_dir   = (r_op == 8'h02);
  assign bus_addr  = r_addr;
  assign bus_len   = r_len;
  assign bus_wdata = r_wdata;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Directed testbench for cmd_dispatch
// NCH=4, MAX_LEN=4 with short timeouts.
module tb_cmd_dispatch;
  localparam int NCH = 4;
  localparam int ML  = 4;
  localparam int RXT = 50;
  localparam int BT  = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        bus_start;
  logic [1:0]  bus_ch;
  logic        bus_dir;
  logic [7:0]  bus_addr;
  logic [4:0]  bus_len;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_done = 1'b0;
  logic        bus_err = 1'b0;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;
  int e_err  = 0;
  int starts = 0;
  logic [1:0]  c_ch;
  logic        c_dir;
  logic [7:0]  c_addr;
  logic [4:0]  c_len;
  logic [31:0] c_wd;
  logic [7:0]  txq[$];
  logic [7:0]  exp_q[$];
  logic [7:0]  frm[$];

  cmd_dispatch #(
    .NCH(NCH), .MAX_LEN(ML), .RX_TMO(RXT), .BUS_TMO(BT)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_start(bus_start), .bus_ch(bus_ch), .bus_dir(bus_dir),
    .bus_addr(bus_addr), .bus_len(bus_len), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_done(bus_done), .bus_err(bus_err),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_start) begin
      starts <= starts + 1;
      c_ch   <= bus_ch;
      c_dir  <= bus_dir;
      c_addr <= bus_addr;
      c_len  <= bus_len;
      c_wd   <= bus_wdata;
    end
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    while (!rx_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_accept got=0 want=1 byte=%h", b);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frm();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic wait_start(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (starts != base) ok = 1'b1;
    end
  endtask

  task automatic bus_reply(input logic [31:0] rd, input logic er);
    bus_rdata = rd;
    bus_err   = er;
    bus_done  = 1'b1;
    @(posedge clk);
    #1;
    bus_done  = 1'b0;
    bus_err   = 1'b0;
  endtask

  task automatic wait_tx(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (txq.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || bus_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b%b%b want=000",
               rx_ready, tx_valid, bus_start);
    end
    checks++;
    if ({bus_ch, bus_dir, bus_addr, bus_len} !== 16'h0 ||
        bus_wdata !== 32'h0 || tx_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_bus got=%h %h want=0 0",
               {bus_ch, bus_dir, bus_addr, bus_len}, bus_wdata);
    end
    checks++;
    if (err_count !== 8'h00) begin
      errors++;
      $display("FAIL reset_err got=%h want=00", err_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL idle_rx_ready got=%b want=1", rx_ready);
    end
  endtask

  task automatic test_write_maxlen();
    int base, sb;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h55, 8'h5D, 8'h01, 8'h03, 8'h7F, 8'h04,
             8'h11, 8'h22, 8'h33, 8'h44, 8'h3D, 8'h0D, 8'h0A};
    send_frm();
    wait_start(sb, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL maxlen_start got=none want=start");
    end
    checks++;
    if ({c_ch, c_dir, c_addr, c_len} !== {2'd3, 1'b0, 8'h7F, 5'd4} ||
        c_wd !== 32'h44332211) begin
      errors++;
      $display("FAIL maxlen_bus got=%h %h want=%h 44332211",
               {c_ch, c_dir, c_addr, c_len}, c_wd,
               {2'd3, 1'b0, 8'h7F, 5'd4});
    end
    bus_reply(32'h0, 1'b0);
    exp_q = '{8'h55, 8'h5D, 8'h00, 8'h00, 8'h0D, 8'h0A};
    wait_tx(base + exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL maxlen_resp_len got=%0d want=%0d",
               txq.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txq[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL maxlen_resp[%0d] got=%h want=%h",
                   i, txq[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_write();
    int base, sb;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h12, 8'h55, 8'h55, 8'h5D, 8'h01, 8'h02, 8'h10,
             8'h02, 8'hAA, 8'hBB, 8'h00, 8'h0D, 8'h0A};
    send_frm();
    wait_start(sb, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_start got=none want=start");
    end
    checks++;
    if ({c_ch, c_dir, c_addr, c_len} !== {2'd2, 1'b0, 8'h10, 5'd2} ||
        c_wd !== 32'h0000BBAA) begin
      errors++;
      $display("FAIL write_bus got=%h %h want=%h 0000bbaa",
               {c_ch, c_dir, c_addr, c_len}, c_wd,
               {2'd2, 1'b0, 8'h10, 5'd2});
    end
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b0 || bus_start !== 1'b0 ||
        bus_addr !== 8'h10 || bus_wdata !== 32'h0000BBAA) begin
      errors++;
      $display("FAIL write_wait got=%b%b %h %h want=00 10 0000bbaa",
               rx_ready, bus_start, bus_addr, bus_wdata);
    end
    bus_reply(32'h0, 1'b0);
    exp_q = '{8'h55, 8'h5D, 8'h00, 8'h00, 8'h0D, 8'h0A};
    wait_tx(base + exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL write_resp_len got=%0d want=%0d",
               txq.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txq[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL write_resp[%0d] got=%h want=%h",
                   i, txq[base+i], exp_q[i]);
        end
      end
    end
    repeat (10) @(posedge clk);
    checks++;
    if (starts != sb + 1 || txq.size() != base + 6) begin
      errors++;
      $display("FAIL write_once got=%0d/%0d want=%0d/%0d",
               starts, txq.size(), sb + 1, base + 6);
    end
  endtask

  task automatic test_read(input string nm);
    int base, sb;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h55, 8'h5D, 8'h02, 8'h01, 8'h20, 8'h02,
             8'h21, 8'h0D, 8'h0A};
    send_frm();
    wait_start(sb, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_start got=none want=start", nm);
    end
    checks++;
    if ({c_ch, c_dir, c_addr, c_len} !== {2'd1, 1'b1, 8'h20, 5'd2}) begin
      errors++;
      $display("FAIL %s_bus got=%h want=%h", nm,
               {c_ch, c_dir, c_addr, c_len}, {2'd1, 1'b1, 8'h20, 5'd2});
    end
    bus_reply(32'hFFFF3412, 1'b0);
    exp_q = '{8'h55, 8'h5D, 8'h00, 8'h12, 8'h34, 8'h26, 8'h0D, 8'h0A};
    wait_tx(base + exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_resp_len got=%0d want=%0d", nm,
               txq.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txq[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL %s_resp[%0d] got=%h want=%h",
                   nm, i, txq[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_bad_csum();
    int base, sb;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h55, 8'h5D, 8'h01, 8'h02, 8'h10, 8'h02,
             8'hAA, 8'hBB, 8'h01, 8'h0D, 8'h0A};
    send_frm();
    exp_q = '{8'h55, 8'h5D, 8'hE1, 8'hE1, 8'h0D, 8'h0A};
    wait_tx(base + exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL csum_resp_len got=%0d want=%0d",
               txq.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txq[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL csum_resp[%0d] got=%h want=%h",
                   i, txq[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (starts != sb) begin
      errors++;
      $display("FAIL csum_no_bus got=%0d want=%0d", starts, sb);
    end
  endtask

  task automatic test_bus_err();
    int base, sb;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h55, 8'h5D, 8'h02, 8'h01, 8'h20, 8'h02,
             8'h21, 8'h0D, 8'h0A};
    send_frm();
    wait_start(sb, ok);
    bus_reply(32'h00003412, 1'b1);
    exp_q = '{8'h55, 8'h5D, 8'hE3, 8'hE3, 8'h0D, 8'h0A};
    wait_tx(base + exp_q.size(), ok);
    repeat (5) @(posedge clk);
    checks++;
    if (txq.size() != base + exp_q.size()) begin
      errors++;
      $display("FAIL buserr_resp_len got=%0d want=%0d",
               txq.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txq[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL buserr_resp[%0d] got=%h want=%h",
                   i, txq[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_bad_frames();
    int base, sb;
    base = txq.size();
    sb   = starts;
    for (int k = 0; k < 5; k++) begin
      unique case (k)
        0: frm = '{8'h55, 8'h5D, 8'h02, 8'h05, 8'h20, 8'h02};
        1: frm = '{8'h55, 8'h5D, 8'h03};
        2: frm = '{8'h55, 8'h5D, 8'h01, 8'h00, 8'h00, 8'h00};
        3: frm = '{8'h55, 8'h5D, 8'h01, 8'h00, 8'h00, 8'h05};
        default: frm = '{8'h55, 8'h5D, 8'h01, 8'h02, 8'h10, 8'h02,
                         8'hAA, 8'hBB, 8'h00, 8'h0E, 8'h0A};
      endcase
      send_frm();
      e_err++;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (err_count !== 8'(e_err)) begin
        errors++;
        $display("FAIL bad_frame%0d_err got=%0d want=%0d",
                 k, err_count, e_err);
      end
    end
    checks++;
    if (starts != sb || txq.size() != base) begin
      errors++;
      $display("FAIL bad_frame_quiet got=%0d/%0d want=%0d/%0d",
               starts, txq.size(), sb, base);
    end
  endtask

  task automatic test_bus_timeout();
    int base, sb, n;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h55, 8'h5D, 8'h02, 8'h01, 8'h20, 8'h02,
             8'h21, 8'h0D, 8'h0A};
    send_frm();
    wait_start(sb, ok);
    n = 0;
    while (!tx_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n < BT || n > BT + 1) begin
      errors++;
      $display("FAIL bus_tmo_delay got=%0d want=%0d", n, BT);
    end
    exp_q = '{8'h55, 8'h5D, 8'hE2, 8'hE2, 8'h0D, 8'h0A};
    wait_tx(base + exp_q.size(), ok);
    bus_reply(32'h00005678, 1'b0);
    repeat (10) @(posedge clk);
    checks++;
    if (txq.size() != base + exp_q.size()) begin
      errors++;
      $display("FAIL bus_tmo_resp_len got=%0d want=%0d",
               txq.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txq[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL bus_tmo_resp[%0d] got=%h want=%h",
                   i, txq[base+i], exp_q[i]);
        end
      end
    end
    checks++;
    if (starts != sb + 1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL bus_tmo_late got=%0d/%b want=%0d/1",
               starts, rx_ready, sb + 1);
    end
  endtask

  task automatic test_stall();
    int base, sb, n;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h55, 8'h5D, 8'h02, 8'h01, 8'h20, 8'h02,
             8'h21, 8'h0D, 8'h0A};
    send_frm();
    wait_start(sb, ok);
    tx_ready = 1'b0;
    bus_reply(32'h00003412, 1'b0);
    n = 0;
    while (!tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
        errors++;
        $display("FAIL stall_hold%0d got=%b/%h want=1/55",
                 i, tx_valid, tx_data);
      end
    end
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      tx_ready = ~tx_ready;
    end
    tx_ready = 1'b1;
    exp_q = '{8'h55, 8'h5D, 8'h00, 8'h12, 8'h34, 8'h26, 8'h0D, 8'h0A};
    wait_tx(base + exp_q.size(), ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL stall_resp_len got=%0d want=%0d",
               txq.size() - base, exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (txq[base+i] !== exp_q[i]) begin
          errors++;
          $display("FAIL stall_resp[%0d] got=%h want=%h",
                   i, txq[base+i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_rx_timeout();
    frm = '{8'h55, 8'h5D, 8'h01};
    send_frm();
    repeat (RXT - 2) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'(e_err)) begin
      errors++;
      $display("FAIL rx_tmo_early got=%0d want=%0d", err_count, e_err);
    end
    repeat (4) @(posedge clk);
    #1;
    e_err++;
    checks++;
    if (err_count !== 8'(e_err)) begin
      errors++;
      $display("FAIL rx_tmo_count got=%0d want=%0d", err_count, e_err);
    end
  endtask

  task automatic test_saturate();
    frm = '{8'h55, 8'h5D, 8'h03};
    for (int k = 0; k < 260; k++) send_frm();
    e_err = 255;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (err_count !== 8'hFF) begin
      errors++;
      $display("FAIL err_saturate got=%h want=ff", err_count);
    end
  endtask

  task automatic test_reset_in_wait();
    int base, sb;
    bit ok;
    base = txq.size();
    sb   = starts;
    frm  = '{8'h55, 8'h5D, 8'h01, 8'h02, 8'h10, 8'h02,
             8'hAA, 8'hBB, 8'h00, 8'h0D, 8'h0A};
    send_frm();
    wait_start(sb, ok);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0 || tx_valid !== 1'b0 || bus_start !== 1'b0 ||
        tx_data !== 8'h00) begin
      errors++;
      $display("FAIL rst_wait_ctl got=%b%b%b %h want=000 00",
               rx_ready, tx_valid, bus_start, tx_data);
    end
    checks++;
    if ({bus_ch, bus_dir, bus_addr, bus_len} !== 16'h0 ||
        bus_wdata !== 32'h0 || err_count !== 8'h00) begin
      errors++;
      $display("FAIL rst_wait_bus got=%h %h %h want=0 0 00",
               {bus_ch, bus_dir, bus_addr, bus_len}, bus_wdata, err_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    e_err = 0;
    bus_reply(32'h00003412, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (txq.size() != base || starts != sb + 1 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_wait_quiet got=%0d/%0d/%b want=%0d/%0d/1",
               txq.size(), starts, rx_ready, base, sb + 1);
    end
  endtask

  initial begin
    test_reset();
    test_write_maxlen();
    test_write();
    test_read("read");
    test_bad_csum();
    test_bus_err();
    test_bad_frames();
    test_read("read_after_err");
    test_bus_timeout();
    test_stall();
    test_rx_timeout();
    test_saturate();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
